// File: rtl/point_spawner.sv
// Keeps up to NUM_POINTS food points on the map: draws LFSR candidates, rejects occupied
// or duplicate tiles via the map probe port, and commits accepted points over a ready/valid write.
module point_spawner #(
    parameter int                MAP_W      = 64,
    parameter int                MAP_H      = 48,
    parameter int                COORD_W    = 6,
    parameter int                NUM_POINTS = 4,
    parameter int                IDX_W      = 2,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
    parameter int                MAX_TRIES  = 8
) (
    input  logic                          clk_75,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          seed_load,
    input  logic [LFSR_W-1:0]             seed_in,
    input  logic                          eat_valid,
    input  logic [IDX_W-1:0]              eat_idx,
    output logic                          probe_req,
    output logic [COORD_W-1:0]            probe_x,
    output logic [COORD_W-1:0]            probe_y,
    input  logic                          probe_empty,
    output logic                          wr_valid,
    output logic [COORD_W-1:0]            wr_x,
    output logic [COORD_W-1:0]            wr_y,
    input  logic                          wr_ready,
    output logic [NUM_POINTS*COORD_W-1:0] points_x,
    output logic [NUM_POINTS*COORD_W-1:0] points_y,
    output logic [NUM_POINTS-1:0]         points_valid,
    output logic                          busy,
    output logic [7:0]                    fail_cnt
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PROBE, S_COMMIT} state_t;

    state_t                        state_q, state_d;
    logic [LFSR_W-1:0]             lfsr_q, lfsr_d, lfsr_step;
    logic [COORD_W-1:0]            cx_q, cx_d, cy_q, cy_d, next_cx, next_cy;
    logic [IDX_W-1:0]              slot_q, slot_d, free_idx;
    logic                          free_any;
    logic [TRY_W-1:0]              tries_q, tries_d;
    logic [7:0]                    fail_q, fail_d;
    logic [NUM_POINTS*COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [NUM_POINTS-1:0]         pv_q, pv_d;
    logic                          dup;

    always_comb begin
        lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        next_cx   = COORD_W'((32'(lfsr_step[7:0]) % (MAP_W - 2)) + 1);
        next_cy   = COORD_W'((32'(lfsr_step[15:8]) % (MAP_H - 2)) + 1);
    end

    // Lowest-index free slot, and whether the latched candidate duplicates a live point.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_POINTS - 1; i >= 0; i--) begin
            if (!pv_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        dup = 1'b0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (pv_q[i] && px_q[i*COORD_W +: COORD_W] == cx_q && py_q[i*COORD_W +: COORD_W] == cy_q)
                dup = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        slot_d  = slot_q;
        tries_d = tries_q;
        fail_d  = fail_q;
        px_d    = px_q;
        py_d    = py_q;
        pv_d    = pv_q;

        for (int i = 0; i < NUM_POINTS; i++) begin
            if (eat_valid && eat_idx == IDX_W'(i))
                pv_d[i] = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (run && free_any) begin
                    state_d = S_DRAW;
                    slot_d  = free_idx;
                    tries_d = '0;
                end
            end
            S_DRAW: begin
                lfsr_d  = lfsr_step;
                cx_d    = next_cx;
                cy_d    = next_cy;
                state_d = S_PROBE;
            end
            S_PROBE: begin
                if (!probe_empty || dup) begin
                    tries_d = tries_q + TRY_W'(1);
                    if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                        state_d = S_IDLE;
                        fail_d  = (fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
                    end else begin
                        state_d = S_DRAW;
                    end
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (wr_ready) begin
                    px_d[slot_q*COORD_W +: COORD_W] = cx_q;
                    py_d[slot_q*COORD_W +: COORD_W] = cy_q;
                    pv_d[slot_q]                    = 1'b1;
                    state_d                         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Leaving game mode abandons any attempt; the LFSR sequence is preserved.
        if (!run) begin
            state_d = S_IDLE;
            lfsr_d  = lfsr_q;
            tries_d = '0;
            fail_d  = fail_q;
            px_d    = px_q;
            py_d    = py_q;
            pv_d    = '0;
        end

        if (seed_load)
            lfsr_d = (seed_in == '0) ? LFSR_W'(1) : seed_in;
    end

    always_ff @(posedge clk_75 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_W'(1);
            cx_q    <= '0;
            cy_q    <= '0;
            slot_q  <= '0;
            tries_q <= '0;
            fail_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            slot_q  <= slot_d;
            tries_q <= tries_d;
            fail_q  <= fail_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pv_q    <= pv_d;
        end
    end

    always_comb begin
        probe_req    = (state_q == S_DRAW);
        probe_x      = probe_req ? next_cx : '0;
        probe_y      = probe_req ? next_cy : '0;
        wr_valid     = (state_q == S_COMMIT);
        wr_x         = wr_valid ? cx_q : '0;
        wr_y         = wr_valid ? cy_q : '0;
        points_x     = px_q;
        points_y     = py_q;
        points_valid = pv_q;
        busy         = (state_q != S_IDLE);
        fail_cnt     = fail_q;
    end

endmodule

// File: tb/tb_point_spawner.sv
// Bench for point_spawner: a per-cycle behavioural reference of the spawning rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_point_spawner;

    localparam int P_IDLE = 0, P_DRAW = 1, P_PROBE = 2, P_COMMIT = 3;

    logic        clk_75 = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        eat_valid = 1'b0;
    logic [1:0]  eat_idx = '0;
    logic        probe_empty = 1'b1;
    logic        wr_ready = 1'b1;
    logic        probe_req, wr_valid, busy;
    logic [5:0]  probe_x, probe_y, wr_x, wr_y;
    logic [23:0] points_x, points_y;
    logic [3:0]  points_valid;
    logic [7:0]  fail_cnt;

    always #5 clk_75 = ~clk_75;

    point_spawner dut (
        .clk_75(clk_75), .rst(rst), .run(run), .seed_load(seed_load), .seed_in(seed_in),
        .eat_valid(eat_valid), .eat_idx(eat_idx),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y), .probe_empty(probe_empty),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_ready(wr_ready),
        .points_x(points_x), .points_y(points_y), .points_valid(points_valid),
        .busy(busy), .fail_cnt(fail_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction
    function automatic int cand_x(input logic [15:0] n);
        return int'(n[7:0]) % 62 + 1;
    endfunction
    function automatic int cand_y(input logic [15:0] n);
        return int'(n[15:8]) % 46 + 1;
    endfunction

    int          m_phase = P_IDLE;
    logic [15:0] m_lfsr = 16'h0001;
    int          m_cx = 0, m_cy = 0, m_slot = 0, m_tries = 0, m_fail = 0;
    int          m_px[4] = '{0, 0, 0, 0};
    int          m_py[4] = '{0, 0, 0, 0};
    bit          m_pv[4] = '{0, 0, 0, 0};

    always @(posedge clk_75 or posedge rst) begin : model
        bit          nv[4];
        bit          hit;
        int          free, nphase;
        logic [15:0] nl;
        if (rst) begin
            m_phase = P_IDLE; m_lfsr = 16'h0001; m_cx = 0; m_cy = 0;
            m_slot = 0; m_tries = 0; m_fail = 0;
            for (int i = 0; i < 4; i++) begin m_px[i] = 0; m_py[i] = 0; m_pv[i] = 0; end
        end else begin
            for (int i = 0; i < 4; i++) nv[i] = m_pv[i];
            nl = m_lfsr;
            nphase = m_phase;
            if (!run) begin
                nphase = P_IDLE;
                m_tries = 0;
                for (int i = 0; i < 4; i++) nv[i] = 0;
            end else begin
                if (eat_valid) nv[eat_idx] = 0;
                if (m_phase == P_IDLE) begin
                    free = -1;
                    for (int i = 3; i >= 0; i--) if (!m_pv[i]) free = i;
                    if (free >= 0) begin nphase = P_DRAW; m_slot = free; m_tries = 0; end
                end else if (m_phase == P_DRAW) begin
                    nl = lfsr_adv(m_lfsr);
                    m_cx = cand_x(nl);
                    m_cy = cand_y(nl);
                    nphase = P_PROBE;
                end else if (m_phase == P_PROBE) begin
                    hit = !probe_empty;
                    for (int i = 0; i < 4; i++)
                        if (m_pv[i] && m_px[i] == m_cx && m_py[i] == m_cy) hit = 1;
                    if (!hit) nphase = P_COMMIT;
                    else begin
                        m_tries++;
                        if (m_tries == 8) begin
                            nphase = P_IDLE;
                            if (m_fail < 255) m_fail++;
                        end else nphase = P_DRAW;
                    end
                end else if (wr_ready) begin
                    m_px[m_slot] = m_cx;
                    m_py[m_slot] = m_cy;
                    nv[m_slot] = 1;
                    nphase = P_IDLE;
                end
            end
            if (seed_load) nl = (seed_in == 16'h0) ? 16'h0001 : seed_in;
            m_lfsr = nl;
            m_phase = nphase;
            for (int i = 0; i < 4; i++) m_pv[i] = nv[i];
        end
    end

    // Compare every cycle on the inactive edge.
    always @(negedge clk_75) begin : compare
        logic [23:0] ex, ey;
        logic [3:0]  ev;
        logic [15:0] n;
        for (int i = 0; i < 4; i++) begin
            ex[i*6 +: 6] = 6'(m_px[i]);
            ey[i*6 +: 6] = 6'(m_py[i]);
            ev[i] = m_pv[i];
        end
        n = lfsr_adv(m_lfsr);
        check("probe_req", probe_req, (m_phase == P_DRAW) ? 1 : 0);
        check("probe_x", probe_x, (m_phase == P_DRAW) ? cand_x(n) : 0);
        check("probe_y", probe_y, (m_phase == P_DRAW) ? cand_y(n) : 0);
        check("wr_valid", wr_valid, (m_phase == P_COMMIT) ? 1 : 0);
        check("wr_x", wr_x, (m_phase == P_COMMIT) ? m_cx : 0);
        check("wr_y", wr_y, (m_phase == P_COMMIT) ? m_cy : 0);
        check("points_x", points_x, ex);
        check("points_y", points_y, ey);
        check("points_valid", points_valid, ev);
        check("busy", busy, (m_phase != P_IDLE) ? 1 : 0);
        check("fail_cnt", fail_cnt, m_fail);
    end

    // ---------------- driver ----------------
    task automatic step();
        @(negedge clk_75);
        #1;
    endtask

    task automatic wait_full(input int budget, input string name);
        int n = 0;
        while (points_valid !== 4'hF && n < budget) begin step(); n++; end
        check(name, points_valid, 4'hF);
    endtask

    task automatic eat(input logic [1:0] idx);
        eat_valid = 1'b1; eat_idx = idx;
        step();
        eat_valid = 1'b0;
    endtask

    initial begin : stim
        int n, probes, early;
        logic [5:0] hx, hy;

        #1 rst = 1'b1;
        step(); step();
        check("rst_probe_req", probe_req, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_points_valid", points_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        rst = 1'b0;
        step();

        // Fill from seed 1.
        seed_load = 1'b1; seed_in = 16'h0001; run = 1'b1;
        step();
        seed_load = 1'b0;
        check("t1_probe_req", probe_req, 1);
        check("t1_probe_x", probe_x, 1);
        check("t1_probe_y", probe_y, 43);
        wait_full(40, "t1_fill");
        check("t1_s0", {points_x[5:0], points_y[5:0]}, {6'd1, 6'd43});
        check("t1_s1", {points_x[11:6], points_y[11:6]}, {6'd1, 6'd45});
        check("t1_s2", {points_x[17:12], points_y[17:12]}, {6'd1, 6'd46});
        check("t1_s3", {points_x[23:18], points_y[23:18]}, {6'd5, 6'd23});
        check("t1_busy", busy, 0);

        // Eat slot 2 and refill.
        eat(2'd2);
        check("t2_valid", points_valid, 4'b1011);
        step();
        check("t2_draw", probe_req, 1);
        check("t2_probe", {probe_x, probe_y}, {6'd3, 6'd12});
        wait_full(20, "t2_fill");
        check("t2_s2", {points_x[17:12], points_y[17:12]}, {6'd3, 6'd12});
        check("t2_s0", {points_x[5:0], points_y[5:0]}, {6'd1, 6'd43});

        // Reseed so the first two candidates duplicate live slots 0 and 1.
        seed_load = 1'b1; seed_in = 16'h0001;
        eat(2'd3);
        seed_load = 1'b0;
        probes = 0; early = 0; n = 0;
        while (points_valid !== 4'hF && n < 30) begin
            step(); n++;
            if (probe_req) probes++;
            if (wr_valid && probes < 3) early++;
        end
        check("t4_probes", probes, 3);
        check("t4_early_write", early, 0);
        check("t4_s3", {points_x[23:18], points_y[23:18]}, {6'd1, 6'd46});
        check("t4_fail_cnt", fail_cnt, 0);

        // Occupied map: attempts fail and retry, fail_cnt saturates.
        probe_empty = 1'b0;
        eat(2'd1);
        probes = 0; n = 0;
        while (fail_cnt == 8'd0 && n < 40) begin
            if (probe_req) probes++;
            step(); n++;
        end
        check("t3_probes", probes, 8);
        check("t3_fail1", fail_cnt, 1);
        check("t3_idle", busy, 0);
        step();
        check("t3_retry", probe_req, 1);
        n = 0;
        while (fail_cnt != 8'd255 && n < 5000) begin step(); n++; end
        repeat (40) step();
        check("t3_sat", fail_cnt, 255);
        probe_empty = 1'b1;
        wait_full(40, "t3_refill");

        // Write backpressure, then drop run.
        wr_ready = 1'b0;
        eat(2'd0);
        n = 0;
        while (!wr_valid && n < 30) begin step(); n++; end
        check("t5_wr_valid", wr_valid, 1);
        hx = wr_x; hy = wr_y;
        repeat (5) begin
            step();
            check("t5_hold", {wr_valid, wr_x, wr_y}, {1'b1, hx, hy});
        end
        run = 1'b0;
        step();
        check("t5_drop_wr", wr_valid, 0);
        check("t5_drop_valid", points_valid, 0);
        run = 1'b1; wr_ready = 1'b1;
        wait_full(100, "t5_refill");

        // Asynchronous reset mid-PROBE, then zero seed.
        eat(2'd0);
        n = 0;
        while (!probe_req && n < 30) begin step(); n++; end
        step();
        rst = 1'b1;
        #1;
        check("t6_probe_req", probe_req, 0);
        check("t6_valid", points_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_fail_cnt", fail_cnt, 0);
        check("t6_points", {points_x, points_y}, 0);
        step();
        rst = 1'b0; seed_load = 1'b1; seed_in = 16'h0000;
        step();
        seed_load = 1'b0;
        check("t6_seed0", {probe_req, probe_x, probe_y}, {1'b1, 6'd1, 6'd43});

        // Randomized traffic.
        repeat (1500) begin
            probe_empty = ($urandom_range(0, 3) != 0);
            wr_ready    = ($urandom_range(0, 2) != 0);
            eat_valid   = ($urandom_range(0, 7) == 0);
            eat_idx     = 2'($urandom_range(0, 3));
            run         = 1'b1;
            if ((m_phase == P_IDLE || m_phase == P_COMMIT) && $urandom_range(0, 49) == 0)
                run = 1'b0;
            seed_load   = !run && ($urandom_range(0, 1) == 1);
            seed_in     = 16'($urandom_range(0, 65535));
            step();
        end
        seed_load = 1'b0; eat_valid = 1'b0; run = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
